// File: rtl/ultrasonic_pkg.sv
// Shared types and default timing for the ultrasonic ranging sequencer.
// Default constants assume a 50 MHz clock.
package ultrasonic_pkg;

    localparam int COUNT_W  = 22;
    localparam int RESULT_W = 21;

    localparam int DEF_TRIG_CYCLES    = 500;
    localparam int DEF_ECHO_TIMEOUT   = 1_900_000;
    localparam int DEF_HOLDOFF_CYCLES = 3_000_000;
    localparam int DEF_NEAR_MIN       = 2950;
    localparam int DEF_NEAR_MAX       = 14750;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_RISE = 3'd2,
        MEASURE   = 3'd3,
        HOLDOFF   = 3'd4
    } state_t;

endpackage

// File: rtl/ultrasonic_sequencer_echo_sync.sv
// Two-flop synchronizer for the asynchronous echo pin, plus one more
// register so rising and falling edges can be detected.
module echo_sync (
    input  logic clk,
    input  logic rst,
    input  logic echo,
    output logic echo_s,
    output logic rise,
    output logic fall
);

    logic sync_p0;
    logic sync_p1;
    logic echo_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            echo_d  <= 1'b0;
        end else begin
            sync_p0 <= echo;
            sync_p1 <= sync_p0;
            echo_d  <= sync_p1;
        end
    end

    // Edges are taken after the synchronizer, so both see identical latency.
    assign echo_s = sync_p1;
    assign rise   = sync_p1 & ~echo_d;
    assign fall   = ~sync_p1 & echo_d;

endmodule

// File: rtl/ultrasonic_sequencer.sv
// One HC-SR04 style ranging cycle: trigger, wait for echo, measure its width,
// then hold off before the next shot (single-shot or free-running).
module ultrasonic_sequencer
    import ultrasonic_pkg::*;
#(
    parameter int TRIG_CYCLES    = DEF_TRIG_CYCLES,
    parameter int ECHO_TIMEOUT   = DEF_ECHO_TIMEOUT,
    parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
    parameter int NEAR_MIN       = DEF_NEAR_MIN,
    parameter int NEAR_MAX       = DEF_NEAR_MAX
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        auto_en,
    input  logic        echo,
    output logic        trig,
    output logic        busy,
    output logic [20:0] echo_cycles,
    output logic        valid,
    output logic        timeout,
    output logic        near
);

    localparam logic [COUNT_W-1:0] TRIG_LAST = COUNT_W'(TRIG_CYCLES - 1);
    localparam logic [COUNT_W-1:0] TO_LAST   = COUNT_W'(ECHO_TIMEOUT - 1);
    localparam logic [COUNT_W-1:0] TO_FULL   = COUNT_W'(ECHO_TIMEOUT);
    localparam logic [COUNT_W-1:0] HOLD_LAST = COUNT_W'(HOLDOFF_CYCLES - 1);

    state_t              state;
    state_t              state_nxt;
    logic [COUNT_W-1:0]  cnt;
    logic [COUNT_W-1:0]  cnt_nxt;
    logic                res_load;
    logic [RESULT_W-1:0] res_cycles;
    logic                res_timeout;

    logic echo_s;
    logic rise;
    logic fall;

    echo_sync u_echo_sync (
        .clk    (clk),
        .rst    (rst),
        .echo   (echo),
        .echo_s (echo_s),
        .rise   (rise),
        .fall   (fall)
    );

    function automatic logic [RESULT_W-1:0] sat_width(input logic [COUNT_W-1:0] c);
        return (c > TO_FULL) ? RESULT_W'(ECHO_TIMEOUT) : c[RESULT_W-1:0];
    endfunction

    function automatic logic near_of(input logic [RESULT_W-1:0] w, input logic to);
        return ~to && (w > RESULT_W'(NEAR_MIN)) && (w < RESULT_W'(NEAR_MAX));
    endfunction

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + COUNT_W'(1);
        res_load    = 1'b0;
        res_cycles  = '0;
        res_timeout = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (start || auto_en) begin
                    state_nxt = TRIG;
                end
            end
            TRIG: begin
                if (cnt == TRIG_LAST) begin
                    state_nxt = WAIT_RISE;
                    cnt_nxt   = '0;
                end
            end
            WAIT_RISE: begin
                // A stale high echo never produces a rise, so it simply times out.
                if (rise) begin
                    state_nxt = MEASURE;
                    cnt_nxt   = COUNT_W'(1);
                end else if (cnt == TO_LAST) begin
                    state_nxt   = HOLDOFF;
                    cnt_nxt     = '0;
                    res_load    = 1'b1;
                    res_timeout = 1'b1;
                end
            end
            MEASURE: begin
                cnt_nxt = echo_s ? cnt + COUNT_W'(1) : cnt;
                if (fall) begin
                    state_nxt  = HOLDOFF;
                    cnt_nxt    = '0;
                    res_load   = 1'b1;
                    res_cycles = sat_width(cnt);
                end else if (cnt >= TO_FULL) begin
                    state_nxt   = HOLDOFF;
                    cnt_nxt     = '0;
                    res_load    = 1'b1;
                    res_cycles  = RESULT_W'(ECHO_TIMEOUT);
                    res_timeout = 1'b1;
                end
            end
            HOLDOFF: begin
                if (cnt == HOLD_LAST) begin
                    state_nxt = auto_en ? TRIG : IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            trig        <= 1'b0;
            busy        <= 1'b0;
            valid       <= 1'b0;
            echo_cycles <= '0;
            timeout     <= 1'b0;
            near        <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            // Pin outputs are registered from the next state to keep them glitch-free.
            trig  <= (state_nxt == TRIG);
            busy  <= (state_nxt != IDLE);
            valid <= res_load;
            if (res_load) begin
                echo_cycles <= res_cycles;
                timeout     <= res_timeout;
                near        <= near_of(res_cycles, res_timeout);
            end
        end
    end

endmodule

// File: tb/tb_ultrasonic_sequencer.sv
// Self-checking bench: a timeline model of each measurement predicts every
// output on every cycle; a few literal checks pin the model itself.
module tb_ultrasonic_sequencer;

    localparam int T    = 50;
    localparam int TO   = 2000;
    localparam int H    = 600;
    localparam int NMIN = 295;
    localparam int NMAX = 1475;
    localparam int BIG  = 1_000_000_000;

    logic        clk = 1'b0;
    logic        rst, start, auto_en, echo;
    logic        trig, busy, valid, timeout, near;
    logic [20:0] echo_cycles;

    ultrasonic_sequencer #(
        .TRIG_CYCLES    (T),
        .ECHO_TIMEOUT   (TO),
        .HOLDOFF_CYCLES (H),
        .NEAR_MIN       (NMIN),
        .NEAR_MAX       (NMAX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .auto_en     (auto_en),
        .echo        (echo),
        .trig        (trig),
        .busy        (busy),
        .echo_cycles (echo_cycles),
        .valid       (valid),
        .timeout     (timeout),
        .near        (near)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // One record per measurement: trigger-entry cycle, result cycle, result, abort cycle.
    int m_ts[$];
    int m_vc[$];
    int m_res[$];
    bit m_to[$];
    int m_ab[$];
    int rst_cyc = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            if (n_bad <= 25)
                $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic bit near_model(input int w, input bit to);
        return !to && (w > NMIN) && (w < NMAX);
    endfunction

    always @(negedge clk) begin
        bit e_trig, e_busy, e_valid;
        int best, e_res;
        bit e_to;
        if (chk_en) begin
            e_trig = 0; e_busy = 0; e_valid = 0; best = -1;
            for (int i = 0; i < m_ts.size(); i++) begin
                if (cyc >= m_ts[i] && cyc < m_ts[i] + T && cyc < m_ab[i]) e_trig = 1;
                if (cyc >= m_ts[i] && cyc < m_vc[i] + H && cyc < m_ab[i]) e_busy = 1;
                if (cyc == m_vc[i] && m_vc[i] < m_ab[i]) e_valid = 1;
                if (m_vc[i] <= cyc && m_vc[i] < m_ab[i] && (best < 0 || m_vc[i] > m_vc[best]))
                    best = i;
            end
            e_res = 0; e_to = 0;
            if (best >= 0 && m_vc[best] > rst_cyc) begin
                e_res = m_res[best];
                e_to  = m_to[best];
            end
            check("trig", int'(trig), int'(e_trig));
            check("busy", int'(busy), int'(e_busy));
            check("valid", int'(valid), int'(e_valid));
            check("echo_cycles", int'(echo_cycles), e_res);
            check("timeout", int'(timeout), int'(e_to));
            check("near", int'(near), int'(near_model(e_res, e_to)));
        end
    end

    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic new_rec(input int ts, output int idx);
        m_ts.push_back(ts);
        m_vc.push_back(BIG);
        m_res.push_back(0);
        m_to.push_back(1'b0);
        m_ab.push_back(BIG);
        idx = m_ts.size() - 1;
    endtask

    task automatic kick(input bit with_auto, output int idx);
        start = 1'b1;
        if (with_auto) auto_en = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        new_rec(cyc, idx);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // w == 0 means no echo at all; w > TO means echo held past the timeout.
    task automatic run_meas(input int idx, input int d, input int w, output int vc);
        int a, r;
        if (w == 0) begin
            vc = m_ts[idx] + T + TO;
            m_res[idx] = 0;
            m_to[idx]  = 1'b1;
            m_vc[idx]  = vc;
            wait_cyc(vc);
        end else begin
            a = m_ts[idx] + T + d;
            wait_cyc(a);
            echo = 1'b1;
            r  = (w < TO) ? w : TO;
            vc = a + 3 + r;
            m_res[idx] = r;
            m_to[idx]  = (w > TO);
            m_vc[idx]  = vc;
            wait_cyc(a + w);
            echo = 1'b0;
            wait_cyc(vc);
        end
    endtask

    task automatic single(input int d, input int w, output int idx, output int vc);
        kick(1'b0, idx);
        run_meas(idx, d, w, vc);
        wait_cyc(vc + H + 5);
    endtask

    initial begin
        int idx, vc, i0, i1, i2, a, widths[6];
        rst = 1'b1; start = 1'b0; auto_en = 1'b0; echo = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        rst_cyc = cyc;
        chk_en = 1'b1;
        check("reset_trig", int'(trig), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_cycles", int'(echo_cycles), 0);
        check("reset_valid", int'(valid), 0);
        wait_cyc(cyc + 10);

        // Basic shot with a start pulse dropped during holdoff.
        kick(1'b0, idx);
        run_meas(idx, 200, 500, vc);
        check("w500_latency", vc - m_ts[idx], 753);
        check("w500_cycles", int'(echo_cycles), 500);
        check("w500_near", int'(near), 1);
        check("w500_timeout", int'(timeout), 0);
        wait_cyc(vc + 10);
        pulse_start();
        wait_cyc(vc + H + 5);

        widths = '{1800, 295, 296, 1474, 1475, 1};
        for (int k = 0; k < 6; k++) begin
            single(40 + k * 7, widths[k], idx, vc);
        end
        check("w1_cycles", int'(echo_cycles), 1);

        // No echo at all.
        single(0, 0, idx, vc);
        check("noecho_latency", vc - m_ts[idx], 2050);
        check("noecho_timeout", int'(timeout), 1);
        check("noecho_cycles", int'(echo_cycles), 0);

        // Echo stuck high before and through the wait window.
        echo = 1'b1;
        wait_cyc(cyc + 10);
        kick(1'b0, idx);
        run_meas(idx, 0, 0, vc);
        wait_cyc(vc + 100);
        echo = 1'b0;
        wait_cyc(vc + H + 5);
        check("stuck_timeout", int'(timeout), 1);

        // Echo rises then stays high past the timeout.
        single(30, 2500, idx, vc);
        check("held_cycles", int'(echo_cycles), 2000);
        check("held_timeout", int'(timeout), 1);

        // Free-running with start asserted together with auto_en.
        kick(1'b1, i0);
        run_meas(i0, 100, 400, vc);
        new_rec(vc + H, i1);
        wait_cyc(vc + 20);
        pulse_start();
        run_meas(i1, 150, 700, vc);
        check("auto_period", m_ts[i1] - m_ts[i0], 1153);
        new_rec(vc + H, i2);
        wait_cyc(m_ts[i2] + 5);
        pulse_start();
        auto_en = 1'b0;
        run_meas(i2, 80, 1000, vc);
        wait_cyc(vc + H + 5);

        // Reset in the middle of a measurement.
        kick(1'b0, idx);
        a = m_ts[idx] + T + 100;
        wait_cyc(a);
        echo = 1'b1;
        m_res[idx] = 1000;
        m_vc[idx]  = a + 1003;
        wait_cyc(a + 400);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_ab[idx] = cyc;
        rst_cyc   = cyc;
        check("midrst_busy", int'(busy), 0);
        check("midrst_trig", int'(trig), 0);
        check("midrst_cycles", int'(echo_cycles), 0);
        wait_cyc(cyc + 20);
        echo = 1'b0;
        wait_cyc(cyc + 20);
        single(60, 600, idx, vc);
        check("after_rst_cycles", int'(echo_cycles), 600);
        check("after_rst_near", int'(near), 1);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
